// File: rtl/csa_pkg.sv
// Shared constants for the nine-operand carry-save adder.
// Holds the datapath width and the operand count.
package csa_pkg;
  localparam int CSA_WIDTH   = 16;
  localparam int CSA_NUM_OPS = 9;
endpackage

// File: rtl/csa_16bit_9num_adder_if.sv
// Operand/result bundle for csa_16bit_9num_adder.
// master: drives in_valid, num0..num8 and reads sum, out_valid. slave: the adder side.
interface csa_16bit_9num_adder_if;
  import csa_pkg::*;

  logic                 in_valid;
  logic [CSA_WIDTH-1:0] num0;
  logic [CSA_WIDTH-1:0] num1;
  logic [CSA_WIDTH-1:0] num2;
  logic [CSA_WIDTH-1:0] num3;
  logic [CSA_WIDTH-1:0] num4;
  logic [CSA_WIDTH-1:0] num5;
  logic [CSA_WIDTH-1:0] num6;
  logic [CSA_WIDTH-1:0] num7;
  logic [CSA_WIDTH-1:0] num8;
  logic [CSA_WIDTH-1:0] sum;
  logic                 out_valid;

  modport master (
    output in_valid,
    output num0, num1, num2,
    output num3, num4, num5,
    output num6, num7, num8,
    input  sum,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  num0, num1, num2,
    input  num3, num4, num5,
    input  num6, num7, num8,
    output sum,
    output out_valid
  );
endinterface

// File: rtl/csa_row_3to2.sv
// Bit-parallel 3:2 compressor row: a+b+c == s+c_shifted (mod 2^WIDTH).
// Ports: a, b, c in; s (xor), c_shifted (majority moved up one bit) out.
module csa_row_3to2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c_shifted
);
  logic [WIDTH-2:0] maj;

  assign s = a ^ b ^ c;

  // Top-bit majority would shift out, so it is never built.
  assign maj = (a[WIDTH-2:0] & b[WIDTH-2:0])
             | (a[WIDTH-2:0] & c[WIDTH-2:0])
             | (b[WIDTH-2:0] & c[WIDTH-2:0]);

  assign c_shifted = {maj, 1'b0};
endmodule

// File: rtl/csa_16bit_9num_adder.sv
// Nine-operand modulo-2^16 adder: 4-level CSA tree, one CPA, one output register.
// Ports: clk, rst_n (async, active-low), bus (slave: operands in, sum/out_valid out).
module csa_16bit_9num_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  csa_16bit_9num_adder_if.slave         bus
);
  logic [WIDTH-1:0] s0, c0, s1, c1, s2, c2;
  logic [WIDTH-1:0] s3, c3, s4, c4;
  logic [WIDTH-1:0] s5, c5;
  logic [WIDTH-1:0] s6, c6;
  logic [WIDTH-1:0] total;

  csa_row_3to2 #(.WIDTH(WIDTH)) u_l1a (
    .a(bus.num0), .b(bus.num1), .c(bus.num2),
    .s(s0), .c_shifted(c0)
  );
  csa_row_3to2 #(.WIDTH(WIDTH)) u_l1b (
    .a(bus.num3), .b(bus.num4), .c(bus.num5),
    .s(s1), .c_shifted(c1)
  );
  csa_row_3to2 #(.WIDTH(WIDTH)) u_l1c (
    .a(bus.num6), .b(bus.num7), .c(bus.num8),
    .s(s2), .c_shifted(c2)
  );

  csa_row_3to2 #(.WIDTH(WIDTH)) u_l2a (
    .a(s0), .b(c0), .c(s1),
    .s(s3), .c_shifted(c3)
  );
  csa_row_3to2 #(.WIDTH(WIDTH)) u_l2b (
    .a(c1), .b(s2), .c(c2),
    .s(s4), .c_shifted(c4)
  );

  // c4 passes straight through to level 4.
  csa_row_3to2 #(.WIDTH(WIDTH)) u_l3 (
    .a(s3), .b(c3), .c(s4),
    .s(s5), .c_shifted(c5)
  );

  csa_row_3to2 #(.WIDTH(WIDTH)) u_l4 (
    .a(s5), .b(c5), .c(c4),
    .s(s6), .c_shifted(c6)
  );

  assign total = s6 + c6;

  // Load only on in_valid so idle-cycle operand garbage never reaches sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid)
        bus.sum <= total;
    end
  end
endmodule

// File: tb/tb_csa_16bit_9num_adder.sv
// Directed and random scoreboard bench for csa_16bit_9num_adder.
// Expected sums are queued at drive time and popped when out_valid is due.
module tb_csa_16bit_9num_adder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [15:0] ops [9];
  logic [15:0] sb [$];
  logic [15:0] last;

  csa_16bit_9num_adder_if bus ();

  csa_16bit_9num_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3,
                         input logic [15:0] v4, input logic [15:0] v5,
                         input logic [15:0] v6, input logic [15:0] v7,
                         input logic [15:0] v8);
    ops[0] = v0; ops[1] = v1; ops[2] = v2;
    ops[3] = v3; ops[4] = v4; ops[5] = v5;
    ops[6] = v6; ops[7] = v7; ops[8] = v8;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 9; i++) ops[i] = v;
  endtask

  // Drive one cycle at negedge, compare the registered result after posedge.
  task automatic step(input string tag, input logic vld);
    logic [15:0] acc;
    logic [15:0] exp;
    @(negedge clk);
    bus.in_valid = vld;
    bus.num0 = ops[0]; bus.num1 = ops[1]; bus.num2 = ops[2];
    bus.num3 = ops[3]; bus.num4 = ops[4]; bus.num5 = ops[5];
    bus.num6 = ops[6]; bus.num7 = ops[7]; bus.num8 = ops[8];
    if (vld) begin
      acc = '0;
      for (int i = 0; i < 9; i++) acc = acc + ops[i];
      sb.push_back(acc);
    end
    @(posedge clk);
    #1;
    if (vld) begin
      chk({tag, "_vld"}, {15'd0, bus.out_valid}, 16'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk({tag, "_sum"}, bus.sum, exp);
        last = exp;
      end else begin
        chk({tag, "_sb_empty"}, 16'd1, 16'd0);
      end
    end else begin
      chk({tag, "_idle_vld"}, {15'd0, bus.out_valid}, 16'd0);
      chk({tag, "_hold"}, bus.sum, last);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last   = '0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    fill(16'h0000);
    bus.num0 = '0; bus.num1 = '0; bus.num2 = '0;
    bus.num3 = '0; bus.num4 = '0; bus.num5 = '0;
    bus.num6 = '0; bus.num7 = '0; bus.num8 = '0;
    #1;
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_vld", {15'd0, bus.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_sum", bus.sum, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload 0x1234, then reset mid-cycle.
    set_ops(16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pre", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sum", bus.sum, 16'h0000);
    chk("async_vld", {15'd0, bus.out_valid}, 16'd0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_edge_sum", bus.sum, 16'h0000);
    chk("rst_edge_vld", {15'd0, bus.out_valid}, 16'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    last = '0;
    #1;
    chk("rel_sum", bus.sum, 16'h0000);
    step("rel_idle", 1'b0);

    set_ops(0, 1, 2, 3, 4, 5, 6, 7, 100);
    step("basic", 1'b1);
    chk("basic_const", bus.sum, 16'h0080);
    step("basic_pulse", 1'b0);

    fill(16'hFFFF);
    step("wrap_ffff", 1'b1);
    chk("wrap_ffff_const", bus.sum, 16'hFFF7);
    fill(16'hAAAA);
    step("wrap_aaaa", 1'b1);
    chk("wrap_aaaa_const", bus.sum, 16'hFFFA);

    set_ops(16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0, 0);
    step("carry_msb", 1'b1);
    chk("carry_msb_const", bus.sum, 16'h0000);
    set_ops(16'h7FFF, 16'h0001, 0, 0, 0, 0, 0, 0, 0);
    step("carry_chain", 1'b1);
    chk("carry_chain_const", bus.sum, 16'h8000);

    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 16'h0001);
    step("only8", 1'b1);
    chk("only8_const", bus.sum, 16'h0001);
    set_ops(0, 0, 0, 0, 16'hBEEF, 0, 0, 0, 0);
    step("only4", 1'b1);
    chk("only4_const", bus.sum, 16'hBEEF);

    for (int k = 0; k < 9; k++) begin
      fill(16'h0000);
      ops[k] = 16'h0101 << (k % 8);
      step("pos", 1'b1);
    end

    set_ops(0, 1, 2, 3, 4, 5, 6, 7, 100);
    step("tp0", 1'b1);
    chk("tp0_const", bus.sum, 16'h0080);
    fill(16'hFFFF);
    step("tp1", 1'b1);
    chk("tp1_const", bus.sum, 16'hFFF7);
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 16'h0001);
    step("tp2", 1'b1);
    chk("tp2_const", bus.sum, 16'h0001);
    fill(16'hDEAD);
    step("tp_idle", 1'b0);
    chk("tp_idle_const", bus.sum, 16'h0001);
    step("tp_idle2", 1'b0);

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 9; i++) ops[i] = 16'($urandom);
      step("rand", ($urandom_range(0, 7) != 0));
    end

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
